// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - steps a 3-input gate through all 8 patterns and checks its truth vector
module truth_table_sweeper #(
    parameter int unsigned SETTLE   = 4,
    parameter logic [7:0]  EXPECTED = 8'h15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth,
    output logic       pass,
    output logic [2:0] fail_idx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] truth_q, truth_d;
    logic       pass_q, pass_d;
    logic [2:0] fail_idx_q, fail_idx_d;
    logic [2:0] abc_q, abc_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        truth_d    = truth_q;
        pass_d     = pass_q;
        fail_idx_d = fail_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    idx_d      = 3'd0;
                    cnt_d      = 8'd0;
                    truth_d    = 8'h00;
                    pass_d     = 1'b0;
                    fail_idx_d = 3'd0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d          = 8'd0;
                    truth_d[idx_q] = d;
                    if (idx_q == 3'd7) begin
                        // Verdict uses the vector including the bit captured on this edge.
                        state_d    = ST_DONE;
                        pass_d     = (truth_d == EXPECTED);
                        fail_idx_d = lowest_set(truth_d ^ EXPECTED);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
                cnt_d   = 8'd0;
            end
        endcase
        // Pattern outputs are registered so the gate under test never sees decode glitches.
        abc_d  = (state_d == ST_DRIVE) ? idx_d : 3'b000;
        busy_d = (state_d == ST_DRIVE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 8'd0;
            truth_q    <= 8'h00;
            pass_q     <= 1'b0;
            fail_idx_q <= 3'd0;
            abc_q      <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            truth_q    <= truth_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
            abc_q      <= abc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign a        = abc_q[2];
    assign b        = abc_q[1];
    assign c        = abc_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign truth    = truth_q;
    assign pass     = pass_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper at SETTLE=4 and SETTLE=1
module tb_truth_table_sweeper;

    localparam logic [7:0] EXP = 8'h15;

    typedef struct packed {
        logic [7:0] t;
        logic       p;
        logic [2:0] f;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [7:0] tbl [2];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] table_v);
        res_t r;
        r.t = table_v;
        r.p = (table_v == EXP);
        r.f = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((table_v[i] != EXP[i]) && (r.f == 3'd0) && (table_v[i-1 -: 1] == table_v[i-1 -: 1])) begin
                if (i == 0 || (((table_v ^ EXP) & ((8'd1 << i) - 8'd1)) == 8'd0)) r.f = 3'(i);
            end
        end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int S = (g == 0) ? 4 : 1;
        logic       a, b, c, d, busy, done, pass;
        logic [7:0] truth;
        logic [2:0] fidx;
        res_t       q[$];
        int         n = 0, e0 = 0, free_at = 0, done_edge = -1, rst_edge = -1;
        bit         active = 0;

        assign d = tbl[g][{a, b, c}];

        truth_table_sweeper #(.SETTLE(S), .EXPECTED(EXP)) dut (
            .clk(clk), .rst(rst), .start(start[g]),
            .a(a), .b(b), .c(c), .d(d),
            .busy(busy), .done(done), .truth(truth), .pass(pass), .fail_idx(fidx)
        );

        // Reference timing: sweep accepted at edge e0 presents pattern i on edges e0+i*S .. e0+(i+1)*S-1.
        always @(posedge clk) begin
            n++;
            if (rst) begin
                active   = 0;
                q.delete();
                free_at  = n + 1;
                rst_edge = n;
            end else if (active) begin
                if (n == e0 + 8 * S) begin
                    active    = 0;
                    done_edge = n;
                    free_at   = n + 2;
                end
            end else if (start[g] && n >= free_at) begin
                active = 1;
                e0     = n;
                q.push_back(model(tbl[g]));
            end
        end

        always @(negedge clk) begin
            res_t r;
            if (n > 0) begin
                chk($sformatf("lane%0d busy n=%0d", g, n), 32'(busy), 32'(active));
                chk($sformatf("lane%0d done n=%0d", g, n), 32'(done), 32'(n == done_edge));
                chk($sformatf("lane%0d abc n=%0d", g, n), 32'({a, b, c}), active ? 32'((n - e0) / S) : 32'd0);
                if ((active && n == e0) || n == rst_edge) begin
                    chk($sformatf("lane%0d truth_clear n=%0d", g, n), 32'(truth), 32'd0);
                    chk($sformatf("lane%0d pass_clear n=%0d", g, n), 32'(pass), 32'd0);
                    chk($sformatf("lane%0d fidx_clear n=%0d", g, n), 32'(fidx), 32'd0);
                end
                if (done === 1'b1) begin
                    if (q.size() == 0) begin
                        chk($sformatf("lane%0d done_without_sweep n=%0d", g, n), 32'd1, 32'd0);
                    end else begin
                        r = q.pop_front();
                        chk($sformatf("lane%0d truth", g), 32'(truth), 32'(r.t));
                        chk($sformatf("lane%0d pass", g), 32'(pass), 32'(r.p));
                        chk($sformatf("lane%0d fail_idx", g), 32'(fidx), 32'(r.f));
                    end
                end
            end
        end
    end

    task automatic do_sweep(input int g, input logic [7:0] t, input int s);
        @(negedge clk);
        tbl[g]   = t;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        repeat (8 * s + 2) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 2'b00;
        tbl[0] = EXP;
        tbl[1] = EXP;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        do_sweep(0, 8'h15, 4);
        do_sweep(0, 8'h00, 4);
        do_sweep(0, 8'hBF, 4);

        // Stray start pulses mid-sweep, then start held across done for a back-to-back sweep.
        @(negedge clk); tbl[0] = 8'h15; start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (4) @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (14) @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (12) @(negedge clk); start[0] = 1'b1;
        repeat (3) @(negedge clk); start[0] = 1'b0;
        repeat (34) @(negedge clk);

        // Reset ten edges into a sweep.
        @(negedge clk); tbl[0] = 8'h15; start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (9) @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        do_sweep(0, 8'h15, 4);

        do_sweep(1, 8'h15, 1);
        do_sweep(1, 8'hBF, 1);

        for (int k = 0; k < 8; k++) begin
            do_sweep(0, ($urandom_range(0, 3) == 0) ? EXP : 8'($urandom), 4);
            do_sweep(1, ($urandom_range(0, 3) == 0) ? EXP : 8'($urandom), 1);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
